// File: rtl/vit_ctrl_if.sv
// Handshake bundle between the Viterbi frame sequencer and its symbol source / datapath.
// The master modport is the controller side, and the slave modport is the environment side.
interface vit_ctrl_if #(
  parameter int AW = 6
);
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    rx_pair;
  logic          frame_end;
  logic [1:0]    bmc_rx;
  logic          acs_en;
  logic          acs_init;
  logic          pm_norm;
  logic          surv_wr_en;
  logic [AW-1:0] surv_wr_addr;
  logic          tb_rd_en;
  logic [AW-1:0] tb_rd_addr;
  logic          tb_first;
  logic          tb_ready;
  logic          tb_done;
  logic          frame_err;
  logic          busy;

  modport master (
    input  in_valid, rx_pair, frame_end, tb_ready,
    output in_ready, bmc_rx, acs_en, acs_init, pm_norm, surv_wr_en, surv_wr_addr,
           tb_rd_en, tb_rd_addr, tb_first, tb_done, frame_err, busy
  );

  modport slave (
    output in_valid, rx_pair, frame_end, tb_ready,
    input  in_ready, bmc_rx, acs_en, acs_init, pm_norm, surv_wr_en, surv_wr_addr,
           tb_rd_en, tb_rd_addr, tb_first, tb_done, frame_err, busy
  );
endinterface

// File: rtl/vit_ctrl.sv
// Viterbi frame sequencer: feeds symbols to BMC/ACS/survivor memory, then walks traceback backwards.
// Optional path-metric normalization pulses are enabled by defining VIT_CTRL_NORM_EN.
module vit_ctrl #(
  parameter int FRAME_MAX   = 64,
  parameter int NORM_PERIOD = 8
) (
  input logic       clk,
  input logic       rst,
  vit_ctrl_if.master bus
);
  localparam int AW = $clog2(FRAME_MAX);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_TRACE} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW-1:0] last_idx_q, last_idx_d;
  logic [1:0]    bmc_rx_q, bmc_rx_d;
  logic          acs_en_q, acs_en_d;
  logic          acs_init_q, acs_init_d;
  logic          pm_norm_q, pm_norm_d;
  logic          surv_wr_en_q, surv_wr_en_d;
  logic [AW-1:0] surv_wr_addr_q, surv_wr_addr_d;
  logic          tb_rd_en_q, tb_rd_en_d;
  logic [AW-1:0] tb_rd_addr_q, tb_rd_addr_d;
  logic          tb_first_q, tb_first_d;
  logic          tb_done_q, tb_done_d;
  logic          frame_err_q, frame_err_d;

  logic in_ready;
  logic accept;
  logic at_max;
  logic last_sym;

  assign in_ready = (state_q == S_IDLE) || (state_q == S_RUN);
  assign accept   = bus.in_valid & in_ready;
  assign at_max   = (idx_q == AW'(FRAME_MAX - 1));
  assign last_sym = bus.frame_end | at_max;

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    last_idx_d     = last_idx_q;
    bmc_rx_d       = bmc_rx_q;
    acs_en_d       = 1'b0;
    acs_init_d     = 1'b0;
    surv_wr_en_d   = 1'b0;
    surv_wr_addr_d = surv_wr_addr_q;
    tb_rd_en_d     = tb_rd_en_q;
    tb_rd_addr_d   = tb_rd_addr_q;
    tb_first_d     = tb_first_q;
    tb_done_d      = 1'b0;
    frame_err_d    = 1'b0;

    case (state_q)
      S_IDLE, S_RUN: begin
        if (accept) begin
          bmc_rx_d       = bus.rx_pair;
          acs_en_d       = 1'b1;
          surv_wr_en_d   = 1'b1;
          surv_wr_addr_d = idx_q;
          acs_init_d     = (idx_q == '0);
          last_idx_d     = idx_q;
          frame_err_d    = at_max & ~bus.frame_end;
          // idx returns to 0 on the last symbol so it is ready for the next frame and never wraps
          if (last_sym) begin
            state_d = S_DRAIN;
            idx_d   = '0;
          end else begin
            state_d = S_RUN;
            idx_d   = idx_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        state_d      = S_TRACE;
        tb_rd_en_d   = 1'b1;
        tb_rd_addr_d = last_idx_q;
        tb_first_d   = 1'b1;
      end
      S_TRACE: begin
        if (tb_rd_en_q && bus.tb_ready) begin
          tb_first_d = 1'b0;
          if (tb_rd_addr_q == '0) begin
            tb_rd_en_d = 1'b0;
            tb_done_d  = 1'b1;
            state_d    = S_IDLE;
          end else begin
            tb_rd_addr_d = tb_rd_addr_q - 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef VIT_CTRL_NORM_EN
  localparam int NW = (NORM_PERIOD > 1) ? $clog2(NORM_PERIOD) : 1;

  logic [NW-1:0] norm_cnt_q, norm_cnt_d;
  logic [NW-1:0] norm_cur;

  // The counter restarts with each frame, so the first symbol accepted from IDLE counts as 0
  always_comb begin
    norm_cur   = (state_q == S_IDLE) ? '0 : norm_cnt_q;
    norm_cnt_d = norm_cnt_q;
    pm_norm_d  = 1'b0;
    if (accept) begin
      pm_norm_d  = (norm_cur == NW'(NORM_PERIOD - 1));
      norm_cnt_d = pm_norm_d ? '0 : norm_cur + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) norm_cnt_q <= '0;
    else      norm_cnt_q <= norm_cnt_d;
  end
`else
  assign pm_norm_d = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      last_idx_q     <= '0;
      bmc_rx_q       <= '0;
      acs_en_q       <= 1'b0;
      acs_init_q     <= 1'b0;
      pm_norm_q      <= 1'b0;
      surv_wr_en_q   <= 1'b0;
      surv_wr_addr_q <= '0;
      tb_rd_en_q     <= 1'b0;
      tb_rd_addr_q   <= '0;
      tb_first_q     <= 1'b0;
      tb_done_q      <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      last_idx_q     <= last_idx_d;
      bmc_rx_q       <= bmc_rx_d;
      acs_en_q       <= acs_en_d;
      acs_init_q     <= acs_init_d;
      pm_norm_q      <= pm_norm_d;
      surv_wr_en_q   <= surv_wr_en_d;
      surv_wr_addr_q <= surv_wr_addr_d;
      tb_rd_en_q     <= tb_rd_en_d;
      tb_rd_addr_q   <= tb_rd_addr_d;
      tb_first_q     <= tb_first_d;
      tb_done_q      <= tb_done_d;
      frame_err_q    <= frame_err_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.bmc_rx       = bmc_rx_q;
  assign bus.acs_en       = acs_en_q;
  assign bus.acs_init     = acs_init_q;
  assign bus.pm_norm      = pm_norm_q;
  assign bus.surv_wr_en   = surv_wr_en_q;
  assign bus.surv_wr_addr = surv_wr_addr_q;
  assign bus.tb_rd_en     = tb_rd_en_q;
  assign bus.tb_rd_addr   = tb_rd_addr_q;
  assign bus.tb_first     = tb_first_q;
  assign bus.tb_done      = tb_done_q;
  assign bus.frame_err    = frame_err_q;
endmodule

// File: tb/tb_vit_ctrl.sv
// Directed bench for vit_ctrl (FRAME_MAX=64): one table-driven frame plus hand-written corner sequences.
module tb_vit_ctrl;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  vit_ctrl_if #(.AW(6)) bus ();

  vit_ctrl #(.FRAME_MAX(64), .NORM_PERIOD(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [1:0]  rx;
    logic        fe;
    logic        tbr;
    logic [23:0] exp;
  } vec_t;

  function automatic logic [23:0] mk(input logic ir, input logic bz, input logic ae, input logic ai,
                                     input logic [1:0] bmc, input logic [5:0] wa, input logic re,
                                     input logic [5:0] ra, input logic fi, input logic dn,
                                     input logic fe, input logic pn);
    return {ir, bz, ae, ai, ae, bmc, wa, re, ra, fi, dn, fe, pn};
  endfunction

  function automatic logic [23:0] obs();
    return {bus.in_ready, bus.busy, bus.acs_en, bus.acs_init, bus.surv_wr_en, bus.bmc_rx,
            bus.surv_wr_addr, bus.tb_rd_en, bus.tb_rd_addr, bus.tb_first, bus.tb_done,
            bus.frame_err, bus.pm_norm};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [1:0] rx, input logic fe, input logic tbr);
    bus.in_valid  = v;
    bus.rx_pair   = rx;
    bus.frame_end = fe;
    bus.tb_ready  = tbr;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int c = 0; c < 200 && bus.busy; c++) step(1'b0, 2'd0, 1'b0, 1'b1);
    check("drain_idle", {31'd0, bus.busy}, 32'd0);
  endtask

  vec_t        tbl[10];
  logic [19:0] norm_mask;
  logic [19:0] norm_exp;
  logic        ferr_early;
  logic        acc_seen;
  logic        done;
  int          exp_a;
  int          bad;
  int          cyc;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.rx_pair   = 2'd0;
    bus.frame_end = 1'b0;
    bus.tb_ready  = 1'b0;

    tbl[0] = '{1'b1, 2'd0, 1'b0, 1'b1, mk(1,1,1,1,2'd0,6'd0,0,6'd0,0,0,0,0)};
    tbl[1] = '{1'b1, 2'd1, 1'b0, 1'b1, mk(1,1,1,0,2'd1,6'd1,0,6'd0,0,0,0,0)};
    tbl[2] = '{1'b1, 2'd2, 1'b0, 1'b1, mk(1,1,1,0,2'd2,6'd2,0,6'd0,0,0,0,0)};
    tbl[3] = '{1'b1, 2'd3, 1'b1, 1'b1, mk(0,1,1,0,2'd3,6'd3,0,6'd0,0,0,0,0)};
    tbl[4] = '{1'b1, 2'd1, 1'b0, 1'b1, mk(0,1,0,0,2'd3,6'd3,1,6'd3,1,0,0,0)};
    tbl[5] = '{1'b0, 2'd0, 1'b0, 1'b1, mk(0,1,0,0,2'd3,6'd3,1,6'd2,0,0,0,0)};
    tbl[6] = '{1'b0, 2'd0, 1'b0, 1'b1, mk(0,1,0,0,2'd3,6'd3,1,6'd1,0,0,0,0)};
    tbl[7] = '{1'b0, 2'd0, 1'b0, 1'b1, mk(0,1,0,0,2'd3,6'd3,1,6'd0,0,0,0,0)};
    tbl[8] = '{1'b0, 2'd0, 1'b0, 1'b1, mk(1,0,0,0,2'd3,6'd3,0,6'd0,0,1,0,0)};
    tbl[9] = '{1'b0, 2'd0, 1'b0, 1'b1, mk(1,0,0,0,2'd3,6'd3,0,6'd0,0,0,0,0)};

    #1;
    check("reset_state", {8'd0, obs()}, {8'd0, 24'h800000});
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      step(tbl[i].v, tbl[i].rx, tbl[i].fe, tbl[i].tbr);
      check($sformatf("frame4_vec%0d", i), {8'd0, obs()}, {8'd0, tbl[i].exp});
    end

    // traceback stalled two cycles on address 2
    for (int i = 0; i < 4; i++) step(1'b1, 2'(i), (i == 3), 1'b0);
    step(1'b0, 2'd0, 1'b0, 1'b0);
    check("stall_first_addr", {24'd0, bus.tb_rd_en, bus.tb_first, bus.tb_rd_addr}, {24'd0, 2'b11, 6'd3});
    step(1'b0, 2'd0, 1'b0, 1'b1);
    check("stall_addr2", {24'd0, bus.tb_rd_en, bus.tb_first, bus.tb_rd_addr}, {24'd0, 2'b10, 6'd2});
    step(1'b1, 2'd1, 1'b0, 1'b0);
    check("stall_hold1", {24'd0, bus.in_ready, bus.acs_en, bus.tb_rd_addr}, {24'd0, 2'b00, 6'd2});
    step(1'b1, 2'd1, 1'b0, 1'b0);
    check("stall_hold2", {24'd0, bus.in_ready, bus.acs_en, bus.tb_rd_addr}, {24'd0, 2'b00, 6'd2});
    step(1'b0, 2'd0, 1'b0, 1'b1);
    check("stall_addr1", {24'd0, bus.tb_rd_en, bus.tb_done, bus.tb_rd_addr}, {24'd0, 2'b10, 6'd1});
    step(1'b0, 2'd0, 1'b0, 1'b1);
    check("stall_addr0", {24'd0, bus.tb_rd_en, bus.tb_done, bus.tb_rd_addr}, {24'd0, 2'b10, 6'd0});
    step(1'b0, 2'd0, 1'b0, 1'b1);
    check("stall_done", {24'd0, bus.tb_rd_en, bus.tb_done, bus.in_ready, 5'd0}, {24'd0, 3'b011, 5'd0});

    // single-symbol frame
    step(1'b1, 2'd2, 1'b1, 1'b1);
    check("single_accept", {24'd0, bus.acs_en, bus.acs_init, bus.in_ready, bus.surv_wr_addr[4:0]}, {24'd0, 3'b110, 5'd0});
    step(1'b0, 2'd0, 1'b0, 1'b1);
    check("single_read", {24'd0, bus.tb_rd_en, bus.tb_first, bus.tb_rd_addr}, {24'd0, 2'b11, 6'd0});
    step(1'b0, 2'd0, 1'b0, 1'b1);
    check("single_done", {24'd0, bus.tb_rd_en, bus.tb_done, bus.in_ready, bus.busy, 4'd0}, {24'd0, 4'b0110, 4'd0});
    step(1'b0, 2'd0, 1'b0, 1'b1);
    check("single_done_pulse", {31'd0, bus.tb_done}, 32'd0);

    // 64 symbols with no frame_end: truncation
    ferr_early = 1'b0;
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 2'(i), 1'b0, 1'b1);
      if (i < 63 && bus.frame_err) ferr_early = 1'b1;
    end
    check("trunc_ferr", {24'd0, bus.frame_err, bus.acs_en, bus.surv_wr_addr}, {24'd0, 2'b11, 6'd63});
    check("trunc_ferr_early", {31'd0, ferr_early}, 32'd0);
    step(1'b1, 2'd0, 1'b0, 1'b1);
    check("trunc_first", {24'd0, bus.tb_rd_en, bus.tb_first, bus.tb_rd_addr}, {24'd0, 2'b11, 6'd63});
    step(1'b1, 2'd0, 1'b0, 1'b1);
    check("trunc_ferr_pulse", {31'd0, bus.frame_err}, 32'd0);
    exp_a = 62; bad = 0; acc_seen = 1'b0; done = 1'b0; cyc = 1;
    if (int'(bus.tb_rd_addr) != exp_a) bad++;
    for (int c = 0; c < 100 && !done; c++) begin
      step(1'b1, 2'd0, 1'b0, 1'b1);
      cyc++;
      if (bus.acs_en) acc_seen = 1'b1;
      if (bus.tb_done) done = 1'b1;
      else begin
        exp_a--;
        if (int'(bus.tb_rd_addr) != exp_a) bad++;
      end
    end
    check("trunc_done_seen", {31'd0, done}, 32'd1);
    check("trunc_trace_cycles", cyc, 32'd64);
    check("trunc_addr_seq_errs", bad, 32'd0);
    check("trunc_no_accept", {31'd0, acc_seen}, 32'd0);
    check("trunc_ready_at_done", {31'd0, bus.in_ready}, 32'd1);
    step(1'b1, 2'd2, 1'b1, 1'b1);
    check("trunc_held_accept", {24'd0, bus.acs_en, bus.acs_init, bus.surv_wr_addr}, {24'd0, 2'b11, 6'd0});
    check("trunc_held_bmc", {30'd0, bus.bmc_rx}, 32'd2);
    drain();

    // normalization over a 20-symbol frame
    norm_mask = '0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 2'(i), (i == 19), 1'b1);
      if (bus.pm_norm) norm_mask[i] = 1'b1;
    end
`ifdef VIT_CTRL_NORM_EN
    norm_exp = 20'h08080;
`else
    norm_exp = 20'h00000;
`endif
    check("norm_mask", {12'd0, norm_mask}, {12'd0, norm_exp});
    drain();

    // asynchronous reset in the middle of a traceback
    for (int i = 0; i < 10; i++) step(1'b1, 2'(i), (i == 9), 1'b1);
    step(1'b0, 2'd0, 1'b0, 1'b1);
    check("mid_trace_start", {26'd0, bus.tb_rd_addr}, 32'd9);
    for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 1'b0, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("async_reset", {8'd0, obs()}, {8'd0, 24'h800000});
    @(posedge clk);
    #1;
    check("reset_held", {8'd0, obs()}, {8'd0, 24'h800000});
    rst = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 2'(i), (i == 2), 1'b1);
    check("post_reset_last", {24'd0, bus.acs_en, bus.in_ready, bus.surv_wr_addr}, {24'd0, 2'b10, 6'd2});
    step(1'b0, 2'd0, 1'b0, 1'b1);
    check("post_reset_a2", {24'd0, bus.tb_rd_en, bus.tb_first, bus.tb_rd_addr}, {24'd0, 2'b11, 6'd2});
    step(1'b0, 2'd0, 1'b0, 1'b1);
    check("post_reset_a1", {24'd0, bus.tb_rd_en, bus.tb_first, bus.tb_rd_addr}, {24'd0, 2'b10, 6'd1});
    step(1'b0, 2'd0, 1'b0, 1'b1);
    check("post_reset_a0", {24'd0, bus.tb_rd_en, bus.tb_first, bus.tb_rd_addr}, {24'd0, 2'b10, 6'd0});
    step(1'b0, 2'd0, 1'b0, 1'b1);
    check("post_reset_done", {30'd0, bus.tb_done, bus.busy}, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/vit_ctrl.md
# vit_ctrl

Frame sequencer for the Viterbi decoder. Accepts received 2-bit symbol pairs and presents each one to the branch-metric units. Drives ACS enable/init, survivor-memory write addressing and optional path-metric normalization. At frame end, it stalls input and walks the traceback unit backwards through survivor memory. It sits between the symbol source and the BMC/ACS/survivor/traceback datapath.

## Interface
- FRAME_MAX, 64: maximum symbols per frame; survivor memory depth. Power of two, ≥2.
- NORM_PERIOD, 8: symbols between normalization pulses; used only with VIT_CTRL_NORM_EN.
- AW, $clog2(FRAME_MAX): address width (derived localparam).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  rx_pair/frame_end valid.
- in_ready  out  1  controller can accept a symbol.
- rx_pair  in  2  received symbol pair.
- frame_end  in  1  marks last symbol of frame; qualified by accept.
- bmc_rx  out  2  registered symbol to BMC units.
- acs_en  out  1  one-cycle ACS update strobe.
- acs_init  out  1  with acs_en on symbol index 0: ACS loads initial metrics.
- pm_norm  out  1  with acs_en: ACS subtracts normalization offset.
- surv_wr_en  out  1  survivor write strobe.
- surv_wr_addr  out  AW  survivor write address = symbol index.
- tb_rd_en  out  1  traceback read request, held until accepted.
- tb_rd_addr  out  AW  traceback read address.
- tb_first  out  1  with first traceback request of a frame.
- tb_ready  in  1  traceback unit accepts current request.
- tb_done  out  1  one-cycle pulse after final (addr 0) request accepted.
- frame_err  out  1  one-cycle pulse: frame truncated at FRAME_MAX.
- busy  out  1  state ≠ IDLE.

## Operation
- Accept = in_valid & in_ready at a rising edge.
- in_ready = 1 in IDLE and RUN, 0 in DRAIN and TRACE.
- States:
  - IDLE: idx=0; accept → RUN, or DRAIN if last.
  - RUN: accept → idx+1; if last → DRAIN.
  - DRAIN: one cycle, unconditionally → TRACE.
  - TRACE: issue reads; accepted read at addr 0 → IDLE.
- last = frame_end | (idx == FRAME_MAX-1).
- If idx == FRAME_MAX-1 and frame_end=0, the frame is truncated and frame_err pulses.
- On accept, registered next edge:
  - bmc_rx←rx_pair.
  - acs_en=surv_wr_en=1, surv_wr_addr←idx.
  - acs_init=(idx==0).
  - last_idx←idx.
- Entering TRACE:
  - tb_rd_en=1, tb_rd_addr=last_idx, tb_first=1.
  - tb_first is held only while the first request is pending.
- In TRACE, each cycle with tb_rd_en & tb_ready:
  - addr>0: addr decrements.
  - addr==0: tb_rd_en←0, tb_done pulses next cycle, state → IDLE.
- tb_rd_addr holds while tb_ready=0.
- in_valid/frame_end without accept are ignored.
- Index arithmetic is unsigned AW-bit and never wraps.
- Single-symbol frame: the trace issues exactly one read, addr 0, with tb_first=1.
- Reset (any time, incl. mid-trace): all outputs 0, idx=0, last_idx=0, state IDLE, normalization counter 0. in_ready=1 after reset.

## Timing
- Accept at edge t → bmc_rx/acs_en/surv_wr_en/surv_wr_addr valid in cycle t+1 (latency 1). Strobes are single-cycle.
- Back-to-back accepts give one acs_en per cycle.
- Last accept at edge t:
  - DRAIN during t+1.
  - First tb_rd_en in cycle t+2.
- With tb_ready=1 continuously:
  - Trace of N symbols occupies N cycles.
  - tb_done is in the cycle after the addr-0 request.
  - in_ready=1 in the same cycle as tb_done.
- frame_err asserts in cycle t+1 alongside the last acs_en.

## Configuration
- VIT_CTRL_NORM_EN defined:
  - A modulo-NORM_PERIOD counter of accepted symbols (reset 0, cleared at frame start).
  - pm_norm=1 with the acs_en of every symbol where count==NORM_PERIOD-1.
  - The counter then wraps to 0.
- Undefined: no counter; pm_norm tied 0.

## Test plan
- Reset mid-TRACE (rst low during trace of 10-symbol frame) → next cycle all outputs 0, busy=0, in_ready=1; a new 3-symbol frame then traces addrs 2,1,0.
- 4 back-to-back symbols 00,01,10,11, frame_end on 4th → bmc_rx 00,01,10,11 in consecutive cycles with surv_wr_addr 0..3. acs_init only with addr 0. Then DRAIN, reads 3,2,1,0, tb_first with 3, tb_done one cycle after 0.
- Trace with tb_ready low 2 cycles on addr 2 → tb_rd_addr holds 2, no skipped/duplicated addresses, in_ready stays 0.
- 64 symbols without frame_end (FRAME_MAX=64) → frame_err pulse with addr-63 write, trace starts at 63, 65th in_valid held until tb_done.
- Single symbol with frame_end → one read at addr 0 with tb_first=1, tb_done next cycle.
- With VIT_CTRL_NORM_EN, NORM_PERIOD=8, 20-symbol frame → pm_norm at symbol indices 7 and 15 only. Without the macro, pm_norm never asserts.
